// File: rtl/adsr_pkg.sv
// adsr_vca shared definitions: envelope state encodings and full-scale constants.
// Optional build macro: ADSR_EXP_RELEASE_EN (exponential release).
package adsr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_e;

  localparam logic [31:0] ACC_MAX    = 32'hFFFF_FFFF;
  localparam logic [15:0] SAMPLE_MAX = 16'h7FFF;
  localparam logic [15:0] SAMPLE_MIN = 16'h8001;

endpackage

// File: rtl/adsr_vca_vca.sv
// Registered VCA: signed sample times unsigned 16-bit gain,
// keeping the top product bits (arithmetic >>> 16, floor rounding).
module adsr_vca_vca #(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OUT_W-1:0] sample_i,
  input  logic [15:0]      gain_i,
  output logic [OUT_W-1:0] sample_o
);

  logic signed [OUT_W+16:0] prod;
  logic [OUT_W-1:0]         sample_d;
  logic [OUT_W-1:0]         sample_q;
  logic                     unused_bits;

  assign prod = $signed(sample_i) * $signed({1'b0, gain_i});
  assign sample_d = prod[OUT_W+15:16];
  assign unused_bits = ^{prod[OUT_W+16], prod[15:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= '0;
    end else begin
      sample_q <= sample_d;
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/adsr_vca.sv
// ADSR envelope generator driving a VCA on the oscillator sample stream.
// Build with ADSR_EXP_RELEASE_EN for exponential release instead of linear.
module adsr_vca
  import adsr_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gate,
  input  logic [ACC_W-1:0] attack_rate,
  input  logic [ACC_W-1:0] decay_rate,
  input  logic [15:0]      sustain,
  input  logic [ACC_W-1:0] release_rate,
  input  logic [OUT_W-1:0] sample_in,
  output logic [OUT_W-1:0] sample_out,
  output logic [15:0]      env_level,
  output logic [2:0]       state,
  output logic             busy
);

  localparam logic [ACC_W-1:0] ACC_TOP = {ACC_W{1'b1}};

  adsr_state_e      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             busy_q;
  logic [ACC_W-1:0] tgt;

  assign tgt = {sustain, {(ACC_W-16){1'b0}}};

`ifdef ADSR_EXP_RELEASE_EN
  logic [ACC_W-1:0] rel_nxt;
  logic [4:0]       rel_sh;
  logic             unused_rel;

  assign rel_sh = release_rate[4:0];
  assign rel_nxt = acc_q - (acc_q >> rel_sh) - ACC_W'(1);
  assign unused_rel = ^release_rate[ACC_W-1:5];
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    unique case (state_q)
      ST_IDLE: begin
        acc_d = '0;
        if (gate) state_d = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (!gate) begin
          state_d = ST_RELEASE;
        end else if (acc_q > ACC_TOP - attack_rate) begin
          acc_d   = ACC_TOP;
          state_d = ST_DECAY;
        end else begin
          acc_d = acc_q + attack_rate;
        end
      end
      ST_DECAY: begin
        if (!gate) begin
          state_d = ST_RELEASE;
        end else if (acc_q <= tgt ||
                     acc_q - tgt <= decay_rate) begin
          acc_d   = tgt;
          state_d = ST_SUSTAIN;
        end else begin
          acc_d = acc_q - decay_rate;
        end
      end
      ST_SUSTAIN: begin
        if (!gate) state_d = ST_RELEASE;
        else       acc_d   = tgt;
      end
      ST_RELEASE: begin
        // retrigger resumes attack from the current level
        if (gate) begin
          state_d = ST_ATTACK;
`ifdef ADSR_EXP_RELEASE_EN
        end else if (acc_q[ACC_W-1 -: 16] == 16'd0 ||
                     rel_sh == 5'd0 ||
                     rel_nxt[ACC_W-1 -: 16] == 16'd0) begin
          acc_d   = '0;
          state_d = ST_IDLE;
        end else begin
          acc_d = rel_nxt;
        end
`else
        end else if (acc_q <= release_rate) begin
          acc_d   = '0;
          state_d = ST_IDLE;
        end else begin
          acc_d = acc_q - release_rate;
        end
`endif
      end
      default: begin
        acc_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign env_level = acc_q[ACC_W-1 -: 16];
  assign state     = state_q;
  assign busy      = busy_q;

  adsr_vca_vca #(
    .OUT_W(OUT_W)
  ) u_vca (
    .clk     (clk),
    .rst     (rst),
    .sample_i(sample_in),
    .gain_i  (env_level),
    .sample_o(sample_out)
  );

endmodule
